// File: rtl/aura_pkg.sv
// rtl/aura_pkg.sv - shared widths, defaults and types for the online-softmax datapath
package aura_pkg;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int SUM_W   = 32;
  localparam int ROW_LEN = 64;
  localparam int ONE_FX  = 1 << FRAC_W;

  typedef logic signed [DATA_W-1:0] INT_T;
  typedef logic [FRAC_W:0]          EXP_T;
  typedef logic [SUM_W-1:0]         SUM_T;
endpackage

// File: rtl/softmax_sum_if.sv
// rtl/softmax_sum_if.sv - score-in / exp-and-sum-out handshake bundle for softmax_sum
interface softmax_sum_if #(
  parameter int DATA_W = aura_pkg::DATA_W,
  parameter int FRAC_W = aura_pkg::FRAC_W,
  parameter int SUM_W  = aura_pkg::SUM_W
) ();
  logic                     vld_in;
  logic                     rdy_out;
  logic signed [DATA_W-1:0] s_i;
  logic signed [DATA_W-1:0] m_i;
  logic signed [DATA_W-1:0] m_i_prev;
  logic                     last_in;
  logic                     vld_out;
  logic                     rdy_in;
  logic [FRAC_W:0]          p_i;
  logic [FRAC_W:0]          alpha;
  logic [SUM_W-1:0]         l_i;
  logic                     last_out;
  logic                     err;

  modport master (
    output vld_in, s_i, m_i, m_i_prev, last_in, rdy_in,
    input  rdy_out, vld_out, p_i, alpha, l_i, last_out, err
  );

  modport slave (
    input  vld_in, s_i, m_i, m_i_prev, last_in, rdy_in,
    output rdy_out, vld_out, p_i, alpha, l_i, last_out, err
  );
endinterface

// File: rtl/exp2_approx.sv
// rtl/exp2_approx.sv - piecewise-linear 2^d for non-positive fixed-point d, unsigned Q1.FRAC_W result
module exp2_approx #(
  parameter int DIFF_W = aura_pkg::DATA_W + 1,
  parameter int FRAC_W = aura_pkg::FRAC_W
) (
  input  logic signed [DIFF_W-1:0] diff,
  output logic [FRAC_W:0]          result
);
  logic signed [DIFF_W-1:0] d_clamp;
  logic signed [DIFF_W-1:0] ip;
  logic [DIFF_W-1:0]        neg_ip;
  logic [FRAC_W:0]          mant;

  always_comb begin
    d_clamp = diff;
    // positive diffs only come from malformed upstream maxima; treat them as 2^0
    if (!diff[DIFF_W-1] && (diff != '0)) begin
      d_clamp = '0;
    end
    ip     = d_clamp >>> FRAC_W;
    neg_ip = $unsigned(-ip);
    mant   = {1'b1, d_clamp[FRAC_W-1:0]};
    if (neg_ip > DIFF_W'(FRAC_W)) begin
      result = '0;
    end else begin
      result = mant >> neg_ip;
    end
  end
endmodule

// File: rtl/softmax_sum.sv
// rtl/softmax_sum.sv - two-stage exp2 and running-denominator stage of the online softmax
module softmax_sum #(
  parameter int DATA_W  = aura_pkg::DATA_W,
  parameter int FRAC_W  = aura_pkg::FRAC_W,
  parameter int SUM_W   = aura_pkg::SUM_W,
  parameter int ROW_LEN = aura_pkg::ROW_LEN
) (
  input  logic         clk,
  input  logic         rst,
  softmax_sum_if.slave bus
);
  localparam int DIFF_W = DATA_W + 1;
  localparam int CNT_W  = $clog2(ROW_LEN + 1);
  localparam logic [FRAC_W:0]      ONE     = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [2*SUM_W-1:0]   SUM_MAX = {{SUM_W{1'b0}}, {SUM_W{1'b1}}};

  logic                     s1_vld, s1_last, s1_first;
  logic signed [DIFF_W-1:0] s1_dp, s1_da;
  logic                     s2_vld, last_q;
  logic [FRAC_W:0]          p_q, a_q;
  logic [SUM_W-1:0]         l_q;
  logic                     first_q, err_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     s1_adv, s2_adv, in_fire;
  logic [FRAC_W:0]          p_exp, a_exp;
  logic [2*SUM_W-1:0]       prod, sum_wide;
  logic [SUM_W-1:0]         l_next;

  assign s2_adv      = !s2_vld || bus.rdy_in;
  assign s1_adv      = !s1_vld || s2_adv;
  assign bus.rdy_out = !s1_vld || s1_adv;
  assign in_fire     = bus.vld_in && bus.rdy_out;

  exp2_approx #(.DIFF_W(DIFF_W), .FRAC_W(FRAC_W)) u_exp_p (.diff(s1_dp), .result(p_exp));
  exp2_approx #(.DIFF_W(DIFF_W), .FRAC_W(FRAC_W)) u_exp_a (.diff(s1_da), .result(a_exp));

  always_comb begin
    prod     = (2*SUM_W)'(l_q) * (2*SUM_W)'(a_exp);
    sum_wide = (prod >> FRAC_W) + (2*SUM_W)'(p_exp);
    if (s1_first) begin
      l_next = SUM_W'(p_exp);
    end else if (sum_wide > SUM_MAX) begin
      l_next = SUM_MAX[SUM_W-1:0];
    end else begin
      l_next = sum_wide[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b1;
      s1_dp    <= '0;
      s1_da    <= '0;
      s2_vld   <= 1'b0;
      last_q   <= 1'b0;
      p_q      <= '0;
      a_q      <= '0;
      l_q      <= '0;
      first_q  <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) begin
        s1_vld <= in_fire;
        if (in_fire) begin
          s1_dp    <= {bus.s_i[DATA_W-1], bus.s_i} - {bus.m_i[DATA_W-1], bus.m_i};
          s1_da    <= {bus.m_i_prev[DATA_W-1], bus.m_i_prev} - {bus.m_i[DATA_W-1], bus.m_i};
          s1_last  <= bus.last_in;
          s1_first <= first_q;
        end
      end
      // row bookkeeping follows accepted inputs, independent of where the beat sits in the pipe
      if (in_fire) begin
        first_q <= bus.last_in;
        if (bus.last_in) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(ROW_LEN)) begin
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          p_q    <= p_exp;
          a_q    <= s1_first ? ONE : a_exp;
          l_q    <= l_next;
          last_q <= s1_last;
        end
      end
    end
  end

  assign bus.vld_out  = s2_vld;
  assign bus.p_i      = p_q;
  assign bus.alpha    = a_q;
  assign bus.l_i      = l_q;
  assign bus.last_out = last_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_softmax_sum.sv
// tb/tb_softmax_sum.sv - randomized self-checking bench for softmax_sum against a behavioural model
module tb_softmax_sum;
  import aura_pkg::*;

  localparam int SAT_W   = 12;
  localparam int SAT_ROW = 1000;

  typedef logic [50:0] rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  softmax_sum_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W)) bus0 ();
  softmax_sum_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SAT_W)) bus1 ();

  softmax_sum #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SUM_W), .ROW_LEN(ROW_LEN))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  softmax_sum #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .SUM_W(SAT_W), .ROW_LEN(SAT_ROW))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int     n_checks = 0;
  int     n_fail   = 0;
  int     acc0     = 0;
  int     acc1     = 0;
  int     cyc      = 0;
  rec_t   exp0[$], got0[$], exp1[$], got1[$];
  bit     m_first[2];
  longint m_l[2];
  int     m_cnt[2];
  bit     m_err[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk_rec(bit last, int p, int a, longint l);
    return {last, 9'(p), 9'(a), 32'(l)};
  endfunction

  // 2^(d/ONE_FX) with linear interpolation between integer powers, d clamped to <= 0
  function automatic int ref_exp2(int d);
    int ip, fp;
    if (d > 0) d = 0;
    ip = d / ONE_FX;
    if (ip * ONE_FX > d) ip = ip - 1;
    fp = d - ip * ONE_FX;
    if (-ip > FRAC_W) return 0;
    return (ONE_FX + fp) / (2 ** (-ip));
  endfunction

  function automatic rec_t model_accept(int id, int s, int m, int mp, bit last);
    longint lmax;
    int     rlen, p, a;
    lmax = (id == 0) ? ((64'd1 << SUM_W) - 1) : ((64'd1 << SAT_W) - 1);
    rlen = (id == 0) ? ROW_LEN : SAT_ROW;
    p = ref_exp2(s - m);
    a = m_first[id] ? ONE_FX : ref_exp2(mp - m);
    if (m_first[id]) m_l[id] = p;
    else m_l[id] = (m_l[id] * a) / ONE_FX + p;
    if (m_l[id] > lmax) m_l[id] = lmax;
    if (!last && m_cnt[id] == rlen) m_err[id] = 1'b1;
    if (last) m_cnt[id] = 0;
    else if (m_cnt[id] != rlen) m_cnt[id] = m_cnt[id] + 1;
    m_first[id] = last;
    return mk_rec(last, p, a, m_l[id]);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_first[i] = 1'b1; m_l[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0;
      end
      exp0.delete(); got0.delete(); exp1.delete(); got1.delete();
    end else begin
      if (bus0.vld_in && bus0.rdy_out) begin
        exp0.push_back(model_accept(0, int'(bus0.s_i), int'(bus0.m_i), int'(bus0.m_i_prev), bus0.last_in));
        acc0 = acc0 + 1;
      end
      if (bus1.vld_in && bus1.rdy_out) begin
        exp1.push_back(model_accept(1, int'(bus1.s_i), int'(bus1.m_i), int'(bus1.m_i_prev), bus1.last_in));
        acc1 = acc1 + 1;
      end
      if (bus0.vld_out && bus0.rdy_in)
        got0.push_back(mk_rec(bus0.last_out, int'(bus0.p_i), int'(bus0.alpha), longint'(bus0.l_i)));
      if (bus1.vld_out && bus1.rdy_in)
        got1.push_back(mk_rec(bus1.last_out, int'(bus1.p_i), int'(bus1.alpha), longint'(bus1.l_i)));
    end
  end

  task automatic set_in(input int id, input bit v, input int s, input int m, input int mp, input bit last);
    if (id == 0) begin
      bus0.vld_in = v; bus0.s_i = 16'(s); bus0.m_i = 16'(m); bus0.m_i_prev = 16'(mp); bus0.last_in = last;
    end else begin
      bus1.vld_in = v; bus1.s_i = 16'(s); bus1.m_i = 16'(m); bus1.m_i_prev = 16'(mp); bus1.last_in = last;
    end
  endtask

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic drive(input int id, input int s, input int m, input int mp, input bit last, output bit ok);
    bit acc;
    ok = 1'b0;
    set_in(id, 1'b1, s, m, mp, last);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = (id == 0) ? bus0.rdy_out : bus1.rdy_out;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    set_in(id, 1'b0, s, m, mp, 1'b0);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (!bus0.vld_out && !bus1.vld_out && got0.size() == exp0.size() && got1.size() == exp1.size()) begin
        ok = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 7;
    if (bus0.vld_out !== 1'b0) begin n_fail++; $display("FAIL rst_vld_out: got %0h want 0", bus0.vld_out); end
    if (bus0.last_out !== 1'b0) begin n_fail++; $display("FAIL rst_last_out: got %0h want 0", bus0.last_out); end
    if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h want 0", bus0.err); end
    if (bus0.p_i !== '0) begin n_fail++; $display("FAIL rst_p: got %0h want 0", bus0.p_i); end
    if (bus0.alpha !== '0) begin n_fail++; $display("FAIL rst_alpha: got %0h want 0", bus0.alpha); end
    if (bus0.l_i !== '0 || bus1.l_i !== '0) begin n_fail++; $display("FAIL rst_l: got %0h/%0h want 0", bus0.l_i, bus1.l_i); end
    if (bus0.rdy_out !== 1'b1) begin n_fail++; $display("FAIL rst_rdy_out: got %0h want 1", bus0.rdy_out); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok, dok;
    drive(0, 256, 256, 0, 1'b1, ok);
    @(posedge clk); #1;
    n_checks += 6;
    if (!ok) begin n_fail++; $display("FAIL single_accept: got timeout want accept"); end
    if (bus0.vld_out !== 1'b1) begin n_fail++; $display("FAIL single_vld: got %0h want 1", bus0.vld_out); end
    if (bus0.p_i !== 9'd256) begin n_fail++; $display("FAIL single_p: got %0d want 256", bus0.p_i); end
    if (bus0.alpha !== 9'd256) begin n_fail++; $display("FAIL single_alpha: got %0d want 256", bus0.alpha); end
    if (bus0.l_i !== 32'd256) begin n_fail++; $display("FAIL single_l: got %0d want 256", bus0.l_i); end
    if (bus0.last_out !== 1'b1) begin n_fail++; $display("FAIL single_last: got %0h want 1", bus0.last_out); end
    drain(dok);
    n_checks++;
    if (got0.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got0.size()); end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_row3();
    rec_t want[3];
    bit ok, all_ok, dok;
    int c0;
    want[0] = mk_rec(1'b0, 256, 256, 256);
    want[1] = mk_rec(1'b0, 128, 256, 384);
    want[2] = mk_rec(1'b1, 256, 64, 352);
    all_ok = 1'b1;
    c0 = cyc;
    drive(0, 0, 0, 0, 1'b0, ok);       all_ok &= ok;
    drive(0, -256, 0, 0, 1'b0, ok);    all_ok &= ok;
    drive(0, 512, 512, 0, 1'b1, ok);   all_ok &= ok;
    n_checks += 2;
    if (!all_ok) begin n_fail++; $display("FAIL row3_accept: got timeout want accept"); end
    if (cyc - c0 != 3) begin n_fail++; $display("FAIL row3_b2b_cycles: got %0d want 3", cyc - c0); end
    drain(dok);
    n_checks++;
    if (got0.size() != 3) begin n_fail++; $display("FAIL row3_count: got %0d want 3", got0.size()); end
    for (int i = 0; i < 3 && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i] !== want[i]) begin n_fail++; $display("FAIL row3_beat%0d: got %0h want %0h", i, got0[i], want[i]); end
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_exp_corners();
    rec_t want[5];
    bit ok, all_ok, dok;
    want[0] = mk_rec(1'b1, 192, 256, 192);
    want[1] = mk_rec(1'b1, 0, 256, 0);
    want[2] = mk_rec(1'b1, 256, 256, 256);
    want[3] = mk_rec(1'b0, 256, 256, 256);
    want[4] = mk_rec(1'b1, 128, 192, 320);
    all_ok = 1'b1;
    drive(0, -128, 0, 0, 1'b1, ok);     all_ok &= ok;
    drive(0, -2560, 0, 0, 1'b1, ok);    all_ok &= ok;
    drive(0, 5, 0, 0, 1'b1, ok);        all_ok &= ok;
    drive(0, 0, 0, 0, 1'b0, ok);        all_ok &= ok;
    drive(0, -256, 0, -128, 1'b1, ok);  all_ok &= ok;
    drain(dok);
    n_checks += 2;
    if (!(all_ok && dok)) begin n_fail++; $display("FAIL exp_timeout: got timeout want completion"); end
    if (got0.size() != 5) begin n_fail++; $display("FAIL exp_count: got %0d want 5", got0.size()); end
    for (int i = 0; i < 5 && i < got0.size(); i++) begin
      n_checks++;
      if (got0[i] !== want[i]) begin n_fail++; $display("FAIL exp_corner%0d: got %0h want %0h", i, got0[i], want[i]); end
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_backpressure();
    bit ok, all_ok, dok, done, snap_v;
    int base, a0, s, m, mp;
    rec_t snap, cur;
    all_ok = 1'b1; done = 1'b0; snap_v = 1'b0; snap = '0;
    bus0.rdy_in = 1'b1;
    base = acc0;
    fork
      begin
        for (int r = 0; r < 2; r++) begin
          for (int i = 0; i < 10; i++) begin
            m  = int'($urandom_range(0, 4000)) - 2000;
            s  = m - int'($urandom_range(0, 3000));
            mp = m - int'($urandom_range(0, 2000));
            drive(0, s, m, mp, (i == 9), ok);
            all_ok &= ok;
          end
        end
        done = 1'b1;
      end
      begin
        for (int t = 0; t < 300 && (acc0 - base) < 3; t++) begin @(posedge clk); #1; end
        bus0.rdy_in = 1'b0;
        a0 = acc0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          cur = mk_rec(bus0.last_out, int'(bus0.p_i), int'(bus0.alpha), longint'(bus0.l_i));
          n_checks++;
          if (k == 0) begin
            snap = cur; snap_v = bus0.vld_out;
            if (snap_v !== 1'b1) begin n_fail++; $display("FAIL bp_stall_vld: got %0h want 1", snap_v); end
          end else if (cur !== snap || bus0.vld_out !== snap_v) begin
            n_fail++; $display("FAIL bp_stable%0d: got %0h want %0h", k, cur, snap);
          end
          @(posedge clk); #1;
        end
        n_checks++;
        if (acc0 - a0 > 2) begin n_fail++; $display("FAIL bp_rdy_drop: got %0d accepts want <=2", acc0 - a0); end
        for (int t = 0; t < 3000 && !done; t++) begin
          bus0.rdy_in = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus0.rdy_in = 1'b1;
      end
    join
    drain(dok);
    n_checks += 2;
    if (!(all_ok && dok)) begin n_fail++; $display("FAIL bp_timeout: got timeout want completion"); end
    if (got0.size() != exp0.size() || exp0.size() != 20) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d (model %0d)", got0.size(), 20, exp0.size());
    end
    foreach (exp0[i]) begin
      if (i < got0.size()) begin
        n_checks++;
        if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %0h want %0h", i, got0[i], exp0[i]); end
      end
    end
    got0.delete(); exp0.delete();
  endtask

  task automatic test_saturation();
    bit ok, all_ok, dok;
    longint want_l;
    all_ok = 1'b1;
    bus1.rdy_in = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(1, 0, 0, 0, (i == 20), ok);
      all_ok &= ok;
    end
    drain(dok);
    n_checks += 2;
    if (!(all_ok && dok)) begin n_fail++; $display("FAIL sat_timeout: got timeout want completion"); end
    if (got1.size() != 21) begin n_fail++; $display("FAIL sat_count: got %0d want 21", got1.size()); end
    for (int i = 0; i < 21 && i < got1.size(); i++) begin
      want_l = 256 * (i + 1);
      if (want_l > (1 << SAT_W) - 1) want_l = (1 << SAT_W) - 1;
      n_checks++;
      if (got1[i] !== mk_rec((i == 20), 256, 256, want_l)) begin
        n_fail++; $display("FAIL sat_beat%0d: got %0h want l=%0d", i, got1[i], want_l);
      end
    end
    got1.delete(); exp1.delete();
  endtask

  task automatic test_overflow_reset();
    bit ok, all_ok, dok;
    all_ok = 1'b1;
    bus0.rdy_in = 1'b1;
    for (int i = 0; i < ROW_LEN; i++) begin drive(0, 0, 0, 0, 1'b0, ok); all_ok &= ok; end
    n_checks++;
    if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early: got %0h want 0", bus0.err); end
    drive(0, 0, 0, 0, 1'b0, ok); all_ok &= ok;
    n_checks += 2;
    if (bus0.err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %0h want 1", bus0.err); end
    if (bus0.err !== m_err[0]) begin n_fail++; $display("FAIL ovf_err_model: got %0h want %0h", bus0.err, m_err[0]); end
    for (int i = 0; i < 3; i++) begin drive(0, -64, 0, -32, 1'b0, ok); all_ok &= ok; end
    n_checks++;
    if (bus0.err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %0h want 1", bus0.err); end
    drain(dok);
    n_checks += 2;
    if (!(all_ok && dok)) begin n_fail++; $display("FAIL ovf_timeout: got timeout want completion"); end
    if (got0.size() != exp0.size() || exp0.size() != ROW_LEN + 4) begin
      n_fail++; $display("FAIL ovf_count: got %0d want %0d", got0.size(), ROW_LEN + 4);
    end
    foreach (exp0[i]) begin
      if (i < got0.size()) begin
        n_checks++;
        if (got0[i] !== exp0[i]) begin n_fail++; $display("FAIL ovf_beat%0d: got %0h want %0h", i, got0[i], exp0[i]); end
      end
    end
    got0.delete(); exp0.delete();
    drive(0, 0, 0, 0, 1'b0, ok);
    drive(0, 0, 0, 0, 1'b0, ok);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks += 3;
    if (bus0.err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %0h want 0", bus0.err); end
    if (bus0.vld_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vld: got %0h want 0", bus0.vld_out); end
    if (bus0.l_i !== '0) begin n_fail++; $display("FAIL rst_mid_l: got %0h want 0", bus0.l_i); end
    rst = 1'b1;
    all_ok = 1'b1;
    drive(0, -256, 0, -1000, 1'b0, ok); all_ok &= ok;
    drive(0, 0, 0, 0, 1'b1, ok);         all_ok &= ok;
    drain(dok);
    n_checks += 2;
    if (!(all_ok && dok) || got0.size() != 2) begin
      n_fail++; $display("FAIL post_rst_count: got %0d want 2", got0.size());
    end
    if (got0.size() > 0 && got0[0] !== mk_rec(1'b0, 128, 256, 128)) begin
      n_fail++; $display("FAIL post_rst_first: got %0h want %0h", got0[0], mk_rec(1'b0, 128, 256, 128));
    end
    if (got0.size() > 1) begin
      n_checks++;
      if (got0[1] !== mk_rec(1'b1, 256, 256, 384)) begin
        n_fail++; $display("FAIL post_rst_second: got %0h want %0h", got0[1], mk_rec(1'b1, 256, 256, 384));
      end
    end
    got0.delete(); exp0.delete();
  endtask

  initial begin
    rst = 1'b0;
    set_in(0, 1'b0, 0, 0, 0, 1'b0);
    set_in(1, 1'b0, 0, 0, 0, 1'b0);
    bus0.rdy_in = 1'b1;
    bus1.rdy_in = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_row3();
    test_exp_corners();
    test_backpressure();
    test_saturation();
    test_overflow_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1);
  end
endmodule

// File: doc/softmax_sum.md
Name: softmax_sum

Overview:
- Downstream consumer of the running-max stage in the online-softmax datapath.
- Per score, accepts the score s_i, the updated running max m_i and the prior max m_i_prev.
- Computes p_i = 2^(s_i - m_i) and the rescale factor alpha = 2^(m_i_prev - m_i).
- Maintains the per-row running denominator l_i = l_prev*alpha + p_i.
- Feeds p_i, alpha and l_i to the PV accumulate stage over the same valid/ready handshake the max stage uses.

Parameters:
- DATA_W, 16, width of INT_T: signed fixed point, FRAC_W fractional bits.
- FRAC_W, 8, fractional bits of scores and of the exp outputs.
- SUM_W, 32, width of the unsigned running sum l_i (FRAC_W fractional bits).
- ROW_LEN, 64, maximum number of scores per row; also sets the elem_cnt width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- vld_in  in  1  upstream beat valid
- rdy_out  out  1  this block can accept a beat
- s_i  in  DATA_W  score (INT_T)
- m_i  in  DATA_W  running max including s_i (INT_T)
- m_i_prev  in  DATA_W  running max before s_i (INT_T); ignored on the first beat of a row
- last_in  in  1  beat is the final score of a row
- vld_out  out  1  output beat valid
- rdy_in  in  1  downstream ready
- p_i  out  FRAC_W+1  2^(s_i - m_i), unsigned Q1.FRAC_W
- alpha  out  FRAC_W+1  2^(m_i_prev - m_i), unsigned Q1.FRAC_W; forced 1.0 on the first beat of a row
- l_i  out  SUM_W  running denominator after this beat
- last_out  out  1  last_in delayed with the beat
- err  out  1  sticky: a row exceeded ROW_LEN beats without last_in

Behaviour:
- Reset (rst=0 at a clk edge):
  - vld_out, last_out and err = 0; p_i, alpha and l_i = 0.
  - Internal l register = 0, first flag = 1, elem_cnt = 0, all stage valids = 0.
  - Reset mid-row discards all in-flight beats.
- Handshake:
  - An input beat transfers when vld_in && rdy_out; an output beat transfers when vld_out && rdy_in.
  - Outputs hold stable while vld_out && !rdy_in.
  - rdy_out may depend combinationally on rdy_in; vld_out must not depend combinationally on vld_in.
- Pipeline: two register stages, latency 2 cycles, throughput 1 beat/cycle when rdy_in is held at 1.
  - S1: registers d_p = s_i - m_i and d_a = m_i_prev - m_i, both DATA_W+1 signed, plus last_in and the first flag.
  - S2: evaluates exp2 on both diffs, updates l, and drives the output registers.
  - A stage advances iff it is empty or the stage after it advances.
  - rdy_out = !s1_vld || s1_adv.
- exp2(d), d in Q.FRAC_W and expected <= 0:
  - If d > 0, clamp d = 0.
  - ip = floor(d), computed as an arithmetic right shift by FRAC_W; fp = d[FRAC_W-1:0].
  - Result = ((1<<FRAC_W) + fp) >> (-ip).
  - Result = 0 when -ip > FRAC_W.
  - Examples (FRAC_W=8): d=0 -> 256; d=-256 -> 128; d=-128 -> 192; d=-2560 -> 0.
- Sum update on S2 advance:
  - First beat of a row: l = p.
  - Otherwise: l = ((l * alpha) >> FRAC_W) + p, with a 2*SUM_W-bit intermediate.
  - Saturate l at 2^SUM_W - 1.
  - l_i drives the updated value.
- Row tracking:
  - The first flag is set by reset and by an accepted beat with last_in=1; it is cleared by any other accepted beat.
  - elem_cnt increments per accepted input and resets to 0 on an accepted last_in.
  - Accepting a beat when elem_cnt == ROW_LEN without last_in sets err. The beat is still processed and elem_cnt saturates. err is cleared only by reset.
- A single-beat row (first and last on the same beat) gives l = p and last_out = 1.

Decomposition:
- aura_pkg holds:
  - INT_T typedef (logic signed [DATA_W-1:0]);
  - DATA_W, FRAC_W, SUM_W and ROW_LEN defaults;
  - ONE_FX = 1<<FRAC_W;
  - EXP_T typedef (FRAC_W+1 bits);
  - SUM_T typedef.
- One sub-module, exp2_approx: purely combinational, diff in, EXP_T out. It is instantiated twice in S2.

Test Plan:
- Reset then a single beat with s=m=0x0100 and last=1, rdy_in=1:
  - after 2 cycles: vld_out=1, p=256, alpha=256, l=256, last_out=1.
- Row of 3 beats, rdy_in=1, values (s, m, m_prev):
  - beat 1: (0, 0, x) -> l=256.
  - beat 2: (-256, 0, 0) -> p=128, l=384.
  - beat 3: (512, 512, 0) -> p=256, alpha=64, l=352, last_out=1.
  - Back-to-back accepts with no bubbles.
- Backpressure: hold rdy_in=0 for 5 cycles mid-row.
  - rdy_out must drop within 2 accepted beats.
  - Outputs stay stable.
  - No beat is lost or duplicated, checked against a reference model.
- Exp corners: d=-128 -> 192; d=-2560 -> 0; d=+5 (malformed input) -> clamped to 256.
- Sum saturation: drive 2^SUM_W worth of p=256 beats, with ROW_LEN overridden large:
  - l_i pins at 0xFFFFFFFF.
- Row overflow and reset:
  - ROW_LEN+1 beats without last_in -> err=1 and stays 1.
  - Assert rst mid-row -> err, vld_out and l clear.
  - The next beat is treated as first, so l = p.
